// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between write-back and a small MD result FIFO.
// MD results drain into idle WB cycles; a wait counter forces an MD write after MAX_WAIT denials.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_val,
  output logic        wb_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_dest,
  input  logic [31:0] md_val,
  output logic        md_ready,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        Write_EN,
  output logic [4:0]  dest,
  output logic [31:0] Write_val
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   val_mem  [DEPTH];
  logic [AW-1:0] head_reg, tail_reg;
  logic [AW:0]   count_reg, count_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;

  logic wb_req, fifo_req, force_md, pop, push;
  logic [DEPTH-1:0] hit1_vec, hit2_vec;

  assign wb_req   = wb_we && (wb_dest != 5'd0);
  assign fifo_req = (count_reg != '0);
  assign force_md = fifo_req && (wait_cnt_reg == WAIT_MAX);
  assign pop      = !rst && (force_md || (fifo_req && !wb_req));
  // Acceptance depends only on registered occupancy, never on this cycle's pop.
  assign md_ready = !rst && (count_reg != FULL_CNT);
  assign push     = md_valid && md_ready && (md_dest != 5'd0);

  always_comb begin
    Write_EN  = 1'b0;
    dest      = 5'd0;
    Write_val = 32'd0;
    wb_stall  = 1'b0;
    if (pop) begin
      Write_EN  = 1'b1;
      dest      = dest_mem[head_reg];
      Write_val = val_mem[head_reg];
      wb_stall  = force_md && wb_req;
    end else if (!rst && wb_req) begin
      Write_EN  = 1'b1;
      dest      = wb_dest;
      Write_val = wb_val;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    wait_cnt_next = wait_cnt_reg;
    if (pop || !fifo_req)
      wait_cnt_next = '0;
    else if (wait_cnt_reg != WAIT_MAX)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      count_reg    <= count_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[tail_reg] <= md_dest;
      val_mem[tail_reg]  <= md_val;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] slot_off;
      logic          slot_valid;
      assign slot_off     = AW'(gi) - head_reg;
      assign slot_valid   = ({1'b0, slot_off} < count_reg);
      assign hit1_vec[gi] = slot_valid && (dest_mem[gi] == src1);
      assign hit2_vec[gi] = slot_valid && (dest_mem[gi] == src2);
    end
  endgenerate

  assign pend_hit1 = !rst && (src1 != 5'd0) && (|hit1_vec);
  assign pend_hit2 = !rst && (src2 != 5'd0) && (|hit2_vec);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-based model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, md_valid, wb_stall, md_ready, pend_hit1, pend_hit2, Write_EN;
  logic [4:0]  wb_dest, md_dest, src1, src2, dest;
  logic [31:0] wb_val, md_val, Write_val;

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_val(wb_val), .wb_stall(wb_stall),
    .md_valid(md_valid), .md_dest(md_dest), .md_val(md_val), .md_ready(md_ready),
    .src1(src1), .src2(src2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .Write_EN(Write_EN), .dest(dest), .Write_val(Write_val)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: queue of pending MD results {dest, val} in acceptance order plus a denial count.
  logic [36:0] q[$];
  int          waited = 0;

  task automatic chk_reset_outputs(input string where);
    chk({where, "_we"},    Write_EN, 0);
    chk({where, "_stall"}, wb_stall, 0);
    chk({where, "_ready"}, md_ready, 0);
    chk({where, "_hit1"},  pend_hit1, 0);
    chk({where, "_hit2"},  pend_hit2, 0);
    chk({where, "_dest"},  dest, 0);
    chk({where, "_val"},   Write_val, 0);
  endtask

  initial begin
    bit          hold_wb, hold_md;
    int          wb_pct;
    bit          e_wb_req, e_force, e_fifo, e_ready, e_stall, e_we, h1, h2;
    logic [4:0]  e_dest;
    logic [31:0] e_val;

    rst = 1'b1;
    wb_we = 1'b1; wb_dest = 5'd5; wb_val = 32'h11;
    md_valid = 1'b1; md_dest = 5'd7; md_val = 32'hAB;
    src1 = 5'd7; src2 = 5'd5;
    #3;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    wb_we = 1'b0; md_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("idle_we", Write_EN, 0);
    chk("idle_ready", md_ready, 1);
    chk("idle_hit1", pend_hit1, 0);
    chk("idle_hit2", pend_hit2, 0);

    hold_wb = 0; hold_md = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      case ((cyc / 250) % 4)
        0: wb_pct = 95;
        1: wb_pct = 50;
        2: wb_pct = 10;
        default: wb_pct = 100;
      endcase
      if (!hold_wb) begin
        wb_we   = ($urandom_range(99) < wb_pct);
        wb_dest = 5'($urandom_range(7));
        wb_val  = $urandom;
      end
      if (!hold_md) begin
        md_valid = ($urandom_range(99) < 50);
        md_dest  = 5'($urandom_range(7));
        md_val   = $urandom;
      end
      src1 = 5'($urandom_range(7));
      src2 = 5'($urandom_range(7));
      #3;

      e_wb_req = wb_we && wb_dest != 0;
      e_fifo   = q.size() > 0;
      e_force  = e_fifo && waited == MAX_WAIT;
      e_ready  = q.size() < DEPTH;
      e_stall  = 0; e_we = 0; e_dest = 0; e_val = 0;
      if (e_force || (e_fifo && !e_wb_req)) begin
        e_we = 1; e_dest = q[0][36:32]; e_val = q[0][31:0];
        e_stall = e_force && e_wb_req;
      end else if (e_wb_req) begin
        e_we = 1; e_dest = wb_dest; e_val = wb_val;
      end
      h1 = 0; h2 = 0;
      foreach (q[i]) begin
        if (src1 != 0 && q[i][36:32] == src1) h1 = 1;
        if (src2 != 0 && q[i][36:32] == src2) h2 = 1;
      end

      chk("write_en", Write_EN, e_we);
      chk("dest", dest, e_dest);
      chk("write_val", Write_val, e_val);
      chk("wb_stall", wb_stall, e_stall);
      chk("md_ready", md_ready, e_ready);
      chk("pend_hit1", pend_hit1, h1);
      chk("pend_hit2", pend_hit2, h2);
      $display("cyc %0d: we=%0b dest=%0d val=%h stall=%0b ready=%0b q=%0d wait=%0d",
               cyc, Write_EN, dest, Write_val, wb_stall, md_ready, q.size(), waited);

      // Advance the model by one clock edge.
      if (!e_fifo) waited = 0;
      else if (e_we && e_dest == q[0][36:32] && (e_force || !e_wb_req)) begin
        void'(q.pop_front());
        waited = 0;
      end else if (waited < MAX_WAIT) waited++;
      if (md_valid && e_ready && md_dest != 0) q.push_back({md_dest, md_val});
      hold_wb = e_stall;
      hold_md = md_valid && !e_ready;

      if (cyc % 400 == 200) begin
        wb_we = 1'b1; wb_dest = 5'd9;
        rst = 1'b1;
        #0.5;
        chk_reset_outputs("midrst");
        wb_we = 1'b0; md_valid = 1'b0;
        q.delete();
        waited = 0;
        hold_wb = 0; hold_md = 0;
        @(posedge clk); #2;
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
